retire_rat: RTL
===============

// Module: retire_rat
// PURPOSE
//   Retirement-side consumer of the reorder buffer's commit port. Holds the retirement
//   register alias table (R-RAT, arch -> phys) and the physical-register free list.
//   Each commit with a register update installs the new mapping and frees the previous
//   physical register. The rename stage pulls free registers from this block's allocate port.
// PARAMETERS
//   NUM_ARCH_REGS  `PROJ_NUM_ARCH_REGS (32)  architectural registers; arch reg 0 is hard-zero
//   NUM_PHYS_REGS  `PROJ_NUM_PHYS_REGS (64)  physical registers; must exceed NUM_ARCH_REGS
//   LA = $clog2(NUM_ARCH_REGS), LP = $clog2(NUM_PHYS_REGS), LC = LP+1 (derived)
// PORTS
//   CLK              in   1   single clock, all state updates on posedge
//   RESET            in   1   synchronous, active-high
//   Commit_IN        in   1   ROB retired its head entry this cycle (ReadyCommit)
//   RegUpdate_IN     in   1   retired entry writes a register
//   Arch_reg_IN      in   LA  destination arch reg of retired entry
//   Phys_reg_IN      in   LP  phys reg holding its result
//   Alloc_req_IN     in   1   rename stage takes one free phys reg
//   Alloc_valid_OUT  out  1   free list non-empty (registered count != 0)
//   Alloc_phys_OUT   out  LP  phys reg at free-list head; valid when Alloc_valid_OUT
//   Free_count_OUT   out  LC  registered number of free phys regs
//   Rd_arch_IN       in   LA  recovery/debug read address
//   Rd_phys_OUT      out  LP  R-RAT[Rd_arch_IN], combinational, pre-update value
//   Error_OUT        out  1   sticky protocol-violation flag
// BEHAVIOUR
//   Reset (RESET=1 at posedge): R-RAT[i]=i for all i; free list = NUM_ARCH_REGS..
//     NUM_PHYS_REGS-1 in ascending order, head=0, tail=count=NUM_PHYS_REGS-NUM_ARCH_REGS;
//     Error_OUT=0. Reset mid-operation discards all pending state; same-cycle inputs ignored.
//   Free list: circular FIFO, depth NUM_PHYS_REGS, head/tail wrap modulo depth, count in LC bits.
//   Commit: when Commit_IN & RegUpdate_IN & Arch_reg_IN!=0: old=R-RAT[Arch_reg_IN];
//     R-RAT[Arch_reg_IN]<=Phys_reg_IN; push old at tail. Visible next cycle (1-cycle latency).
//   Commit with RegUpdate_IN=0, or Arch_reg_IN==0: no table change, no free, no error.
//   Commit with Phys_reg_IN==old: table unchanged, nothing freed, Error_OUT<=1.
//   RegUpdate_IN/Arch/Phys ignored when Commit_IN=0.
//   Allocate: Alloc_req_IN & Alloc_valid_OUT pops head; Alloc_phys_OUT shows next entry
//     next cycle. Alloc_req_IN while empty: no pop, no state change, Error_OUT<=1.
//   Simultaneous pop and push: both occur, count unchanged. If count==0 the freed reg is
//     NOT bypassed to the allocate port that cycle; available next cycle.
//   Push while count==NUM_PHYS_REGS (impossible if protocol held): push dropped, Error_OUT<=1.
//   Error_OUT stays 1 until RESET.
//   Invariant: count + (NUM_ARCH_REGS) + phys regs in flight == NUM_PHYS_REGS.
// TESTING
//   1 Reset, defaults 32/64 -> Free_count_OUT=32, Alloc_phys_OUT=32, Rd_phys_OUT(arch 5)=5.
//   2 Commit arch5->phys40 -> next cycle Rd_phys(5)=40, count=33, phys5 at free-list tail;
//     after 32 pops the 33rd Alloc_phys_OUT=5.
//   3 Commit arch0->phys41, and commit with RegUpdate_IN=0 -> R-RAT, count unchanged, Error=0.
//   4 Drain 32 allocs -> Alloc_valid_OUT=0; same cycle commit arch3->phys33 plus Alloc_req
//     -> no grant, count=1, Alloc_phys_OUT=3 next cycle; Alloc_req at empty sets Error_OUT.
//   5 count=10, alloc+commit same cycle, 100 iterations with head/tail wrapping -> count stays
//     10, freed order matches commit order, no duplicate phys reg ever allocated.
//   6 Assert RESET mid-stream with Commit_IN=1 -> full reset state, commit discarded, Error=0.

Source files
------------

// File: rtl/retire_rat.sv
// rtl/retire_rat.sv - retirement register alias table and physical-register free list
// Commits install arch->phys mappings and recycle the previous phys reg to the rename allocator.
module retire_rat #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int NUM_PHYS_REGS = 64,
  localparam int LA = $clog2(NUM_ARCH_REGS),
  localparam int LP = $clog2(NUM_PHYS_REGS),
  localparam int LC = LP + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          Commit_IN,
  input  logic          RegUpdate_IN,
  input  logic [LA-1:0] Arch_reg_IN,
  input  logic [LP-1:0] Phys_reg_IN,
  input  logic          Alloc_req_IN,
  output logic          Alloc_valid_OUT,
  output logic [LP-1:0] Alloc_phys_OUT,
  output logic [LC-1:0] Free_count_OUT,
  input  logic [LA-1:0] Rd_arch_IN,
  output logic [LP-1:0] Rd_phys_OUT,
  output logic          Error_OUT
);

  logic [LP-1:0] rat [NUM_ARCH_REGS];
  logic [LP-1:0] free_list [NUM_PHYS_REGS];
  logic [LP-1:0] head;
  logic [LP-1:0] tail;
  logic [LC-1:0] count;
  logic          error;

  logic [LP-1:0] old_phys;
  logic          commit_upd;
  logic          same_phys;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          err_set;

  function automatic logic [LP-1:0] wrap_inc(input logic [LP-1:0] ptr);
    return (ptr == LP'(NUM_PHYS_REGS - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign old_phys   = rat[Arch_reg_IN];
  assign commit_upd = Commit_IN && RegUpdate_IN && (Arch_reg_IN != '0);
  assign same_phys  = commit_upd && (Phys_reg_IN == old_phys);
  assign full       = (count == LC'(NUM_PHYS_REGS));
  assign empty      = (count == '0);
  // A freed reg is never bypassed: pop decisions look only at the registered count.
  assign push       = commit_upd && !same_phys && !full;
  assign pop        = Alloc_req_IN && !empty;
  assign err_set    = same_phys || (commit_upd && !same_phys && full) || (Alloc_req_IN && empty);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) begin
        rat[i] <= LP'(i);
      end
      for (int i = 0; i < NUM_PHYS_REGS; i++) begin
        free_list[i] <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? LP'(NUM_ARCH_REGS + i) : '0;
      end
      head  <= '0;
      tail  <= LP'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      count <= LC'(NUM_PHYS_REGS - NUM_ARCH_REGS);
      error <= 1'b0;
    end else begin
      // The mapping still moves when only the push is dropped on a full list.
      if (commit_upd && !same_phys) begin
        rat[Arch_reg_IN] <= Phys_reg_IN;
      end
      if (push) begin
        free_list[tail] <= old_phys;
        tail            <= wrap_inc(tail);
      end
      if (pop) begin
        head <= wrap_inc(head);
      end
      count <= count + LC'(push) - LC'(pop);
      if (err_set) begin
        error <= 1'b1;
      end
    end
  end

  assign Alloc_valid_OUT = !empty;
  assign Alloc_phys_OUT  = free_list[head];
  assign Free_count_OUT  = count;
  assign Rd_phys_OUT     = rat[Rd_arch_IN];
  assign Error_OUT       = error;

endmodule
